pid_output_limiter: RTL and testbench

- Downstream stage of pid_controller: consumes its 29-bit signed data_out and produces a 14-bit signed DAC word.
- Pipeline: programmable arithmetic right-shift (gain scaling), clamp to a programmable [min_val, max_val] window, then slew-rate limiter.
- An enable/hold state machine provides soft start, soft stop and output freeze, so loop turn-on or turn-off never steps the actuator.

---
 rtl/pid_output_limiter.sv | 99 +++++++++
 tb/tb_pid_output_limiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_output_limiter.sv
// pid_output_limiter: shift, clamp and slew-limit a PID result into a DAC word, with soft start/stop and hold.
// Define PID_LIMITER_STATS_EN to add sat_clr/sat_count saturation statistics.
module pid_output_limiter #(
  parameter int IN_WIDTH    = 29,
  parameter int OUT_WIDTH   = 14,
  parameter int SHIFT_WIDTH = 5,
  parameter int STEP_WIDTH  = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        hold,
  input  logic signed [IN_WIDTH-1:0]  din,
  input  logic [SHIFT_WIDTH-1:0]      shift,
  input  logic signed [OUT_WIDTH-1:0] min_val,
  input  logic signed [OUT_WIDTH-1:0] max_val,
  input  logic [STEP_WIDTH-1:0]       max_step,
`ifdef PID_LIMITER_STATS_EN
  input  logic                        sat_clr,
  output logic [31:0]                 sat_count,
`endif
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        saturated,
  output logic                        slewing,
  output logic [1:0]                  state
);
  typedef enum logic [1:0] {OFF, RAMP, TRACK, HOLD} state_t;
  state_t                      r_state;
  logic signed [IN_WIDTH-1:0]  r_s1;
  logic signed [OUT_WIDTH-1:0] r_target, r_dout;
  logic                        r_sat2, r_sat, r_slew;
  logic signed [IN_WIDTH-1:0]  w_min, w_max;
  logic                        w_inv, w_lo, w_hi;
  logic signed [OUT_WIDTH-1:0] w_target, w_goal, w_stepped, w_next;
  logic signed [OUT_WIDTH:0]   w_diff;
  logic [OUT_WIDTH:0]          w_mag;
  logic                        w_lim;
  assign w_min    = {{(IN_WIDTH-OUT_WIDTH){min_val[OUT_WIDTH-1]}}, min_val};
  assign w_max    = {{(IN_WIDTH-OUT_WIDTH){max_val[OUT_WIDTH-1]}}, max_val};
  assign w_inv    = min_val > max_val;
  assign w_lo     = r_s1 < w_min;
  assign w_hi     = r_s1 > w_max;
  assign w_target = (w_inv || w_lo) ? min_val : w_hi ? max_val : r_s1[OUT_WIDTH-1:0];
  // Soft stop steers toward zero; otherwise toward the clamped target.
  assign w_goal    = enable ? r_target : '0;
  assign w_diff    = {w_goal[OUT_WIDTH-1], w_goal} - {r_dout[OUT_WIDTH-1], r_dout};
  assign w_mag     = w_diff[OUT_WIDTH] ? -w_diff : w_diff;
  assign w_lim     = (max_step != '0) && (w_mag > (OUT_WIDTH+1)'(max_step));
  assign w_stepped = w_diff[OUT_WIDTH] ? r_dout - OUT_WIDTH'(max_step) : r_dout + OUT_WIDTH'(max_step);
  assign w_next    = w_lim ? w_stepped : w_goal;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= '0;
      r_target <= '0;
      r_sat2   <= 1'b0;
      r_sat    <= 1'b0;
      r_slew   <= 1'b0;
      r_dout   <= '0;
      r_state  <= OFF;
    end else begin
      r_s1     <= din >>> shift;
      r_target <= w_target;
      r_sat2   <= w_inv | w_lo | w_hi;
      r_sat    <= r_sat2;
      if (!enable) begin
        r_state <= OFF;
        r_dout  <= w_next;
        r_slew  <= w_lim;
      end else begin
        r_slew <= 1'b0;
        case (r_state)
          OFF:   r_state <= hold ? HOLD : RAMP;
          RAMP:  if (hold) r_state <= HOLD;
                 else begin
                   r_dout  <= w_next;
                   r_slew  <= w_lim;
                   r_state <= w_lim ? RAMP : TRACK;
                 end
          TRACK: if (hold) r_state <= HOLD;
                 else r_dout <= r_target;
          HOLD:  if (!hold) r_state <= RAMP;
        endcase
      end
    end
  end
  assign dout      = r_dout;
  assign saturated = r_sat;
  assign slewing   = r_slew;
  assign state     = r_state;
`ifdef PID_LIMITER_STATS_EN
  logic [31:0] r_sat_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sat_count <= '0;
    else if (sat_clr) r_sat_count <= '0;
    else if (r_sat && ~&r_sat_count) r_sat_count <= r_sat_count + 32'd1;
  end
  assign sat_count = r_sat_count;
`endif
endmodule

// File: tb/tb_pid_output_limiter.sv
// tb_pid_output_limiter: scoreboard bench for pid_output_limiter plus directed scenario checks.
module tb_pid_output_limiter;
  logic               clk, rst, enable, hold;
  logic signed [28:0] din;
  logic [4:0]         shift;
  logic signed [13:0] min_val, max_val;
  logic [13:0]        max_step;
  logic signed [13:0] dout;
  logic               saturated, slewing;
  logic [1:0]         state;
`ifdef PID_LIMITER_STATS_EN
  logic               sat_clr;
  logic [31:0]        sat_count;
`endif
  int n_chk = 0, n_err = 0;

  pid_output_limiter dut (
    .clk(clk), .rst(rst), .enable(enable), .hold(hold), .din(din), .shift(shift),
    .min_val(min_val), .max_val(max_val), .max_step(max_step),
`ifdef PID_LIMITER_STATS_EN
    .sat_clr(sat_clr), .sat_count(sat_count),
`endif
    .dout(dout), .saturated(saturated), .slewing(slewing), .state(state)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic signed [13:0] d;
    logic [1:0]         st;
    logic               sat;
    logic               slw;
  } exp_t;
  exp_t q[$];

  int m_s1, m_tgt, m_dout, m_st, goal, dd, nd, ms, lo, hi;
  bit m_sat2, m_sat, m_slw, lim;

  // Reference model: pushes the expected outputs for every edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 0; m_tgt = 0; m_dout = 0; m_st = 0;
      m_sat2 = 0; m_sat = 0; m_slw = 0;
      q.delete();
    end else begin
      ms   = int'(max_step);
      goal = enable ? m_tgt : 0;
      dd   = goal - m_dout;
      lim  = (ms != 0) && (dd > ms || dd < -ms);
      nd   = lim ? (dd > 0 ? m_dout + ms : m_dout - ms) : goal;
      if (!enable) begin m_st = 0; m_dout = nd; m_slw = lim; end
      else if (m_st == 0) begin m_st = hold ? 3 : 1; m_slw = 0; end
      else if (hold) begin m_st = 3; m_slw = 0; end
      else if (m_st == 3) begin m_st = 1; m_slw = 0; end
      else if (m_st == 2) begin m_dout = m_tgt; m_slw = 0; end
      else begin m_dout = nd; m_slw = lim; m_st = lim ? 1 : 2; end
      m_sat = m_sat2;
      lo = int'(min_val);
      hi = int'(max_val);
      if (lo > hi) begin m_tgt = lo; m_sat2 = 1; end
      else if (m_s1 < lo) begin m_tgt = lo; m_sat2 = 1; end
      else if (m_s1 > hi) begin m_tgt = hi; m_sat2 = 1; end
      else begin m_tgt = m_s1; m_sat2 = 0; end
      m_s1 = (shift >= 29) ? (din < 0 ? -1 : 0) : (int'(din) >>> shift);
      q.push_back('{d: 14'(m_dout), st: 2'(m_st), sat: m_sat, slw: m_slw});
    end
  end

  exp_t e;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk += 4;
      if (dout !== e.d) begin n_err++; $display("FAIL sb_dout t=%0t: got %0d expected %0d", $time, dout, e.d); end
      if (state !== e.st) begin n_err++; $display("FAIL sb_state t=%0t: got %0d expected %0d", $time, state, e.st); end
      if (saturated !== e.sat) begin n_err++; $display("FAIL sb_saturated t=%0t: got %0b expected %0b", $time, saturated, e.sat); end
      if (slewing !== e.slw) begin n_err++; $display("FAIL sb_slewing t=%0t: got %0b expected %0b", $time, slewing, e.slw); end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1; enable = 0; hold = 0; din = '0; shift = '0;
    min_val = -14'sd8192; max_val = 14'sd8191; max_step = '0;
`ifdef PID_LIMITER_STATS_EN
    sat_clr = 0;
`endif
    tick(2);
    n_chk += 4;
    if (dout !== 14'sd0) begin n_err++; $display("FAIL reset_dout: got %0d expected 0", dout); end
    if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
    if (saturated !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %0b expected 0", saturated); end
    if (slewing !== 1'b0) begin n_err++; $display("FAIL reset_slew: got %0b expected 0", slewing); end
    rst = 0;
  endtask

  task automatic test_ramp;
    max_step = 14'd100; shift = 5'd14; din = 29'(1000 * 16384);
    tick(3);
    enable = 1;
    tick(1);
    n_chk += 2;
    if (state !== 2'd1) begin n_err++; $display("FAIL ramp_enter_state: got %0d expected 1", state); end
    if (dout !== 14'sd0) begin n_err++; $display("FAIL ramp_enter_dout: got %0d expected 0", dout); end
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      n_chk += 3;
      if (dout !== 14'(100 * k)) begin n_err++; $display("FAIL ramp_dout k=%0d: got %0d expected %0d", k, dout, 100 * k); end
      if (slewing !== (k != 10)) begin n_err++; $display("FAIL ramp_slew k=%0d: got %0b expected %0b", k, slewing, k != 10); end
      if (state !== (k == 10 ? 2'd2 : 2'd1)) begin n_err++; $display("FAIL ramp_state k=%0d: got %0d", k, state); end
    end
  endtask

  task automatic test_saturate;
    din = 29'(16000 * 16384);
    tick(2);
    n_chk += 2;
    if (dout !== 14'sd1000) begin n_err++; $display("FAIL sat_early_dout: got %0d expected 1000", dout); end
    if (saturated !== 1'b0) begin n_err++; $display("FAIL sat_early_flag: got %0b expected 0", saturated); end
    tick(1);
    n_chk += 2;
    if (dout !== 14'sd8191) begin n_err++; $display("FAIL sat_hi_dout: got %0d expected 8191", dout); end
    if (saturated !== 1'b1) begin n_err++; $display("FAIL sat_hi_flag: got %0b expected 1", saturated); end
    din = 29'(-16000 * 16384);
    tick(3);
    n_chk += 2;
    if (dout !== -14'sd8192) begin n_err++; $display("FAIL sat_lo_dout: got %0d expected -8192", dout); end
    if (saturated !== 1'b1) begin n_err++; $display("FAIL sat_lo_flag: got %0b expected 1", saturated); end
  endtask

  task automatic test_hold;
    int n;
    hold = 1;
    tick(1);
    din = 29'(500 * 16384);
    tick(4);
    n_chk += 3;
    if (state !== 2'd3) begin n_err++; $display("FAIL hold_state: got %0d expected 3", state); end
    if (dout !== -14'sd8192) begin n_err++; $display("FAIL hold_dout: got %0d expected -8192", dout); end
    if (saturated !== 1'b0) begin n_err++; $display("FAIL hold_sat: got %0b expected 0", saturated); end
    hold = 0; max_step = 14'd50;
    tick(1);
    n_chk += 1;
    if (state !== 2'd1) begin n_err++; $display("FAIL unhold_state: got %0d expected 1", state); end
    n = 0;
    while (state !== 2'd2 && n < 400) begin tick(1); n++; end
    n_chk += 3;
    if (n != 174) begin n_err++; $display("FAIL unhold_steps: got %0d expected 174", n); end
    if (dout !== 14'sd500) begin n_err++; $display("FAIL unhold_dout: got %0d expected 500", dout); end
    if (state !== 2'd2) begin n_err++; $display("FAIL unhold_track: got %0d expected 2", state); end
  endtask

  task automatic test_soft_stop;
    int exp_d[4] = '{700, 400, 100, 0};
    din = 29'(1000 * 16384);
    tick(3);
    n_chk += 1;
    if (dout !== 14'sd1000) begin n_err++; $display("FAIL stop_pre_dout: got %0d expected 1000", dout); end
    enable = 0; max_step = 14'd300;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      n_chk += 2;
      if (dout !== 14'(exp_d[k])) begin n_err++; $display("FAIL stop_dout k=%0d: got %0d expected %0d", k, dout, exp_d[k]); end
      if (state !== 2'd0) begin n_err++; $display("FAIL stop_state k=%0d: got %0d expected 0", k, state); end
    end
    max_step = '0; enable = 1;
    tick(2);
    n_chk += 2;
    if (dout !== 14'sd1000) begin n_err++; $display("FAIL restart_dout: got %0d expected 1000", dout); end
    if (state !== 2'd2) begin n_err++; $display("FAIL restart_state: got %0d expected 2", state); end
    enable = 0;
    tick(1);
    n_chk += 2;
    if (dout !== 14'sd0) begin n_err++; $display("FAIL stop_unlim_dout: got %0d expected 0", dout); end
    if (state !== 2'd0) begin n_err++; $display("FAIL stop_unlim_state: got %0d expected 0", state); end
  endtask

  task automatic test_boundaries;
    enable = 1; shift = 5'd31; din = -29'sd1;
    tick(5);
    n_chk += 2;
    if (dout !== -14'sd1) begin n_err++; $display("FAIL shift31_dout: got %0d expected -1", dout); end
    if (state !== 2'd2) begin n_err++; $display("FAIL shift31_state: got %0d expected 2", state); end
    min_val = 14'sd100; max_val = -14'sd100;
    tick(2);
    n_chk += 2;
    if (dout !== 14'sd100) begin n_err++; $display("FAIL inv_dout: got %0d expected 100", dout); end
    if (saturated !== 1'b1) begin n_err++; $display("FAIL inv_sat: got %0b expected 1", saturated); end
  endtask

  task automatic test_async_reset;
    min_val = -14'sd8192; max_val = 14'sd8191; shift = '0; din = 29'sd5000; max_step = 14'd10;
    hold = 1;
    tick(4);
    hold = 0;
    tick(4);
    n_chk += 2;
    if (state !== 2'd1) begin n_err++; $display("FAIL pre_rst_state: got %0d expected 1", state); end
    if (dout !== 14'sd130) begin n_err++; $display("FAIL pre_rst_dout: got %0d expected 130", dout); end
    #2 rst = 1;
    #1;
    n_chk += 3;
    if (dout !== 14'sd0) begin n_err++; $display("FAIL async_rst_dout: got %0d expected 0", dout); end
    if (state !== 2'd0) begin n_err++; $display("FAIL async_rst_state: got %0d expected 0", state); end
    if (slewing !== 1'b0) begin n_err++; $display("FAIL async_rst_slew: got %0b expected 0", slewing); end
    tick(1);
    rst = 0;
  endtask

`ifdef PID_LIMITER_STATS_EN
  task automatic test_stats;
    min_val = 14'sd100; max_val = -14'sd100; sat_clr = 1;
    tick(3);
    n_chk += 2;
    if (sat_count !== 32'd0) begin n_err++; $display("FAIL stats_clr_hold: got %0d expected 0", sat_count); end
    if (saturated !== 1'b1) begin n_err++; $display("FAIL stats_sat: got %0b expected 1", saturated); end
    sat_clr = 0;
    tick(5);
    n_chk += 1;
    if (sat_count !== 32'd5) begin n_err++; $display("FAIL stats_count: got %0d expected 5", sat_count); end
    sat_clr = 1;
    tick(1);
    n_chk += 1;
    if (sat_count !== 32'd0) begin n_err++; $display("FAIL stats_clear: got %0d expected 0", sat_count); end
    sat_clr = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_ramp;
    test_saturate;
    test_hold;
    test_soft_stop;
    test_boundaries;
    test_async_reset;
`ifdef PID_LIMITER_STATS_EN
    test_stats;
`endif
    tick(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
